// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle for the multicycle MIPS-subset CPU.
// The master modport is the controller side; the slave modport is the datapath/memory side.
interface multicycle_control_if;
  logic       start_i;
  logic [5:0] Op_i;
  logic       MemReady_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic [1:0] PCSource_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       RegDst_o;
  logic       MemtoReg_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALUOp_o;
  logic       IllegalOp_o;
  logic       Retire_o;
  logic [2:0] State_o;

  modport master (
    input  start_i, Op_i, MemReady_i,
    output PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
           ALUOp_o, IllegalOp_o, Retire_o, State_o
  );

  modport slave (
    output start_i, Op_i, MemReady_i,
    input  PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
           ALUOp_o, IllegalOp_o, Retire_o, State_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle main controller: steps each instruction through fetch, decode, execute,
// memory and write-back and drives every datapath select/enable combinationally from state.
module multicycle_control (
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, retire;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    illegal       = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 is computed on the ALU while the instruction is read
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.MemReady_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = bus.Op_i;
        case (bus.Op_i)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_J: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_FETCH;
        case (op_q)
          OP_R:    begin alu_op = 3'b100;                     state_d = S_WB;  end
          OP_ADDI: begin alu_op = 3'b010; alu_src_b = 2'b10;  state_d = S_WB;  end
          OP_LW, OP_SW: begin alu_src_b = 2'b10;              state_d = S_MEM; end
          OP_BEQ: begin
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (bus.MemReady_i) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PCWrite_o     = pc_write;
  assign bus.PCWriteCond_o = pc_write_cond;
  assign bus.PCSource_o    = pc_source;
  assign bus.IorD_o        = iord;
  assign bus.MemRead_o     = mem_read;
  assign bus.MemWrite_o    = mem_write;
  assign bus.IRWrite_o     = ir_write;
  assign bus.RegDst_o      = reg_dst;
  assign bus.MemtoReg_o    = mem_to_reg;
  assign bus.RegWrite_o    = reg_write;
  assign bus.ALUSrcA_o     = alu_src_a;
  assign bus.ALUSrcB_o     = alu_src_b;
  assign bus.ALUOp_o       = alu_op;
  assign bus.IllegalOp_o   = illegal;
  assign bus.Retire_o      = retire;
  assign bus.State_o       = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main controller for the MIPS-subset CPU. Replaces single-cycle opcode decoding with a registered state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and enable: PC, IR, register file, ALU operand muxes, ALU operation and memory port. It sits beside the datapath, takes the opcode from the instruction register and a ready handshake from unified instruction/data memory.

## Interface
- No parameters.
- clk_i  input  1  system clock, all state changes on rising edge
- rst_i  input  1  asynchronous active-high reset
- start_i  input  1  leave IDLE and begin fetching; sampled only in IDLE
- Op_i  input  6  opcode field of the instruction register
- MemReady_i  input  1  memory completes the current read/write this cycle
- PCWrite_o  output  1  unconditional PC load
- PCWriteCond_o  output  1  PC load if ALU zero flag is set (beq)
- PCSource_o  output  2  00 ALU result, 01 ALUOut register, 10 jump target
- IorD_o  output  1  memory address: 0 PC, 1 ALUOut
- MemRead_o  output  1  memory read request
- MemWrite_o  output  1  memory write request
- IRWrite_o  output  1  instruction register load
- RegDst_o  output  1  write register: 0 rt, 1 rd
- MemtoReg_o  output  1  write data: 0 ALUOut, 1 memory data register
- RegWrite_o  output  1  register file write enable
- ALUSrcA_o  output  1  0 PC, 1 register A
- ALUSrcB_o  output  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- ALUOp_o  output  3  000 add, 001 sub, 010 addi, 100 R-type funct decode
- IllegalOp_o  output  1  one-cycle pulse, unsupported opcode seen in DECODE
- Retire_o  output  1  one-cycle pulse in the final cycle of each instruction
- State_o  output  3  current state encoding, for debug

## Operation
- States, State_o encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5. Codes 6 and 7 go to IDLE.
- Outputs are combinational from state, latched opcode op_q and MemReady_i. Any output not listed for a state is 0.
- IDLE: all outputs 0. start_i=1 goes to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - MemReady_i=0: stay in FETCH, request held.
  - MemReady_i=1: IRWrite=1 and PCWrite=1 in the same cycle, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Op_i is latched into op_q on exit.
  - 000000 R-type, 001000 addi, 100011 lw, 101011 sw, 000100 beq: go to EXEC.
  - 000010 j: PCWrite=1, PCSource=10, Retire=1, then FETCH.
  - Any other opcode: IllegalOp=1, then FETCH. No Retire. PC has already advanced.
- EXEC, selected by op_q:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=100, then WB.
  - addi: ALUSrcA=1, ALUSrcB=10, ALUOp=010, then WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, ALUOp=000, then MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, Retire=1, then FETCH.
- MEM: IorD=1. MemRead=1 for lw, MemWrite=1 for sw. Held until MemReady_i=1.
  - On MemReady_i=1: sw asserts Retire and goes to FETCH; lw goes to WB.
- WB: RegWrite=1, Retire=1, then FETCH.
  - R-type: RegDst=1, MemtoReg=0.
  - addi: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
- After the first start_i, the machine never returns to IDLE except on reset. start_i is ignored outside IDLE.
- op_q is not updated outside DECODE. Op_i changes in EXEC/MEM/WB have no effect.

## Timing
- Reset: asynchronous, takes effect immediately and mid-instruction. State=IDLE, op_q=0, all outputs 0 while rst_i is high and until start_i is seen.
- Reset during a MEM or FETCH wait drops MemRead/MemWrite to 0 immediately. The memory must tolerate an abandoned request.
- Cycles per instruction with zero-wait memory (MemReady_i=1 on first request cycle):
  - j 2
  - beq 3
  - R-type 4
  - addi 4
  - sw 4
  - lw 5
- Each cycle of MemReady_i=0 in FETCH or MEM adds exactly one cycle. Request outputs stay stable throughout the wait.
- MemReady_i is ignored in DECODE, EXEC and WB.
- Retire and IllegalOp are never asserted together.
- start_i=1 in the same cycle that rst_i deasserts is ignored. FETCH begins on the first clock edge with rst_i=0 and start_i=1.

## Test plan
- Reset then start_i pulse, Op_i=000000, MemReady_i=1: state sequence 1,2,3,5,1. WB shows RegWrite=1, RegDst=1, ALUOp was 100 in EXEC, Retire pulse at cycle 4.
- lw (100011) with MemReady_i low for 2 cycles in FETCH and 3 in MEM: 10 cycles to retire. MemRead and IorD hold stable through waits. WB shows MemtoReg=1, RegDst=0.
- beq (000100) then j (000010): beq EXEC shows PCWriteCond=1, PCSource=01, ALUOp=001, back to FETCH after 3 cycles. j DECODE shows PCWrite=1, PCSource=10, 2 cycles.
- Op_i=111111: IllegalOp pulses 1 cycle in DECODE, no Retire, no RegWrite/MemWrite, next state FETCH.
- sw (101011) with Op_i changed to 000000 during EXEC: op_q holds, MEM shows MemWrite=1, IorD=1, no WB state, Retire on MemReady_i.
- rst_i asserted mid-MEM wait of sw: MemWrite drops to 0 asynchronously, State_o=0. Machine stays IDLE until start_i=1.
